// File: rtl/llpage_reader_if.sv
// Handshake bundle between llpage_reader and its peers (descriptor source,
// page manager, downstream data reader). The reader uses the master modport.
interface llpage_reader_if #(
    parameter int lpsz = 8
);
    logic            c_srdy;
    logic            c_drdy;
    logic [lpsz-1:0] c_head_page;

    logic            rlp_srdy;
    logic            rlp_drdy;
    logic [lpsz-1:0] rlp_rd_page;

    logic            rlpr_srdy;
    logic            rlpr_drdy;
    logic [lpsz:0]   rlpr_data;

    logic            p_srdy;
    logic            p_drdy;
    logic [lpsz-1:0] p_page;
    logic            p_last;

    logic            drf_srdy;
    logic            drf_drdy;
    logic [lpsz-1:0] drf_page;

    modport master (
        input  c_srdy, c_head_page, rlp_drdy, rlpr_srdy, rlpr_data, p_drdy, drf_drdy,
        output c_drdy, rlp_srdy, rlp_rd_page, rlpr_drdy, p_srdy, p_page, p_last,
               drf_srdy, drf_page
    );

    modport slave (
        output c_srdy, c_head_page, rlp_drdy, rlpr_srdy, rlpr_data, p_drdy, drf_drdy,
        input  c_drdy, rlp_srdy, rlp_rd_page, rlpr_drdy, p_srdy, p_page, p_last,
               drf_srdy, drf_page
    );
endinterface

// File: rtl/llpage_reader.sv
// Linked-list page reader: walks a packet's page chain, emits each page, then dereferences it.
// Optional loop guard enabled by defining LLREADER_LOOP_GUARD_EN.
module llpage_reader #(
    parameter int lpsz  = 8,
    parameter int lpdsz = lpsz + 1,
    parameter int pages = 256
) (
    input  logic            clk,
    input  logic            reset,
    llpage_reader_if.master bus,
    output logic            busy,
    output logic [lpsz:0]   pkt_pages,
    output logic            err
);
    localparam logic [lpsz:0] page_limit = (lpsz + 1)'(pages);

    typedef enum logic [2:0] {IDLE, RDLINK, WAITLINK, EMIT, FREE} state_t;

    state_t          state_q, state_d;
    logic [lpsz-1:0] cur_page_q, cur_page_d;
    logic [lpsz-1:0] nxt_page_q, nxt_page_d;
    logic            last_q, last_d;
    logic [lpsz:0]   page_cnt_q, page_cnt_d;
    logic [lpsz:0]   pkt_pages_q, pkt_pages_d;
    logic [lpdsz-1:0] link_word;

    assign link_word = bus.rlpr_data;

`ifdef LLREADER_LOOP_GUARD_EN
    logic err_q, err_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_page_q  <= '0;
            nxt_page_q  <= '0;
            last_q      <= 1'b0;
            page_cnt_q  <= '0;
            pkt_pages_q <= '0;
`ifdef LLREADER_LOOP_GUARD_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_page_q  <= cur_page_d;
            nxt_page_q  <= nxt_page_d;
            last_q      <= last_d;
            page_cnt_q  <= page_cnt_d;
            pkt_pages_q <= pkt_pages_d;
`ifdef LLREADER_LOOP_GUARD_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_page_d  = cur_page_q;
        nxt_page_d  = nxt_page_q;
        last_d      = last_q;
        page_cnt_d  = page_cnt_q;
        pkt_pages_d = pkt_pages_q;
`ifdef LLREADER_LOOP_GUARD_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.c_srdy) begin
                    cur_page_d = bus.c_head_page;
                    page_cnt_d = '0;
                    state_d    = RDLINK;
                end
            end
            RDLINK: begin
                if (bus.rlp_drdy) state_d = WAITLINK;
            end
            WAITLINK: begin
                if (bus.rlpr_srdy) begin
                    nxt_page_d = link_word[lpsz-1:0];
                    last_d     = link_word[lpsz];
                    // Count saturates at the page pool size so it can never wrap.
                    page_cnt_d = (page_cnt_q >= page_limit) ? page_limit : page_cnt_q + 1'b1;
`ifdef LLREADER_LOOP_GUARD_EN
                    // More links than pages exist means the chain loops; cut it here.
                    if (page_cnt_q >= page_limit && !link_word[lpsz]) begin
                        last_d = 1'b1;
                        err_d  = 1'b1;
                    end
`endif
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.p_drdy) state_d = FREE;
            end
            FREE: begin
                if (bus.drf_drdy) begin
                    if (last_q) begin
                        pkt_pages_d = page_cnt_q;
                        state_d     = IDLE;
                    end else begin
                        cur_page_d = nxt_page_q;
                        state_d    = RDLINK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.c_drdy      = (state_q == IDLE);
    assign bus.rlp_srdy    = (state_q == RDLINK);
    assign bus.rlpr_drdy   = (state_q == WAITLINK);
    assign bus.p_srdy      = (state_q == EMIT);
    assign bus.drf_srdy    = (state_q == FREE);
    assign bus.rlp_rd_page = cur_page_q;
    assign bus.p_page      = cur_page_q;
    assign bus.p_last      = last_q;
    assign bus.drf_page    = cur_page_q;
    assign busy            = (state_q != IDLE);
    assign pkt_pages       = pkt_pages_q;

`ifdef LLREADER_LOOP_GUARD_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_llpage_reader.sv
// Self-checking bench for llpage_reader: a link table plays the page manager,
// and expected transaction lists are derived by walking that table.
module tb_llpage_reader;
    localparam int LPSZ  = 8;
    localparam int PAGES = 4;
    localparam int TMO   = 300;

    logic            clk = 1'b0;
    logic            reset;
    logic            busy;
    logic [LPSZ:0]   pkt_pages;
    logic            err;

    llpage_reader_if #(.lpsz(LPSZ)) bus ();

    llpage_reader #(.lpsz(LPSZ), .lpdsz(LPSZ + 1), .pages(PAGES)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .pkt_pages(pkt_pages),
        .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [LPSZ:0] link_mem [256];

    int exp_rlp[$];
    int exp_p_page[$];
    int exp_p_last[$];
    int exp_drf[$];
    int exp_pkt;
    int exp_err;

    int obs_page[$];
    int obs_last[$];
    int rlp_idx = 0, p_idx = 0, drf_idx = 0;
    int p_fires = 0, drf_fires = 0, err_seen = 0;
    time t_rlp = 0;

    int rlpr_delay = 0;
    bit spur_req = 1'b0;
    int spur_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Expected walk computed straight from the link table.
    task automatic buildChain(input int head);
        int page;
        int cnt;
        int last;
        page = head;
        cnt  = 0;
        exp_err = 0;
        do begin
            cnt++;
            last = int'(link_mem[page][LPSZ]);
`ifdef LLREADER_LOOP_GUARD_EN
            if (cnt > PAGES && last == 0) begin
                last = 1;
                exp_err++;
            end
`endif
            exp_rlp.push_back(page);
            exp_p_page.push_back(page);
            exp_p_last.push_back(last);
            exp_drf.push_back(page);
            page = int'(link_mem[page][LPSZ-1:0]);
        end while (last == 0 && cnt < 1000);
        exp_pkt = (cnt > PAGES) ? PAGES : cnt;
    endtask

    task automatic applyStimulus(input int head, output time t_desc);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.c_srdy      = 1'b1;
        bus.c_head_page = head[LPSZ-1:0];
        do begin
            @(negedge clk);
            n++;
        end while (!bus.c_drdy && n < TMO);
        checkOutput("desc_accept", bus.c_drdy, 1);
        t_desc = $time;
        @(posedge clk); #1;
        bus.c_srdy = 1'b0;
        @(negedge clk);
        checkOutput("rlp_first_cycle", bus.rlp_srdy, 1);
    endtask

    task automatic waitIdle(input string name, output time t_idle);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.c_drdy && drf_idx == exp_drf.size()) && n < TMO);
        checkOutput(name, n < TMO, 1);
        t_idle = $time;
    endtask

    task automatic waitFor(input int which, input string name);
        int n;
        logic hit;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? bus.p_srdy : (which == 1) ? bus.drf_srdy : bus.rlp_srdy;
        end while (!hit && n < TMO);
        checkOutput(name, hit, 1);
    endtask

    // Page manager: answers each accepted link read after rlpr_delay extra cycles.
    bit mgr_rst, mgr_rlp_hs, mgr_rlpr_hs, mgr_emit_wait, pending, spur_active;
    int mgr_pg, pend_page, wait_left;
    initial begin
        bus.rlpr_srdy = 1'b0;
        bus.rlpr_data = '0;
        pending = 1'b0;
        spur_active = 1'b0;
        forever begin
            @(negedge clk);
            mgr_rst       = reset;
            mgr_rlp_hs    = bus.rlp_srdy && bus.rlp_drdy;
            mgr_pg        = int'(bus.rlp_rd_page);
            mgr_rlpr_hs   = bus.rlpr_srdy && bus.rlpr_drdy;
            mgr_emit_wait = bus.p_srdy && !bus.p_drdy;
            @(posedge clk); #1;
            if (mgr_rst) begin
                pending = 1'b0;
                spur_active = 1'b0;
                bus.rlpr_srdy = 1'b0;
            end else begin
                if (mgr_rlpr_hs || spur_active) begin
                    bus.rlpr_srdy = 1'b0;
                    spur_active = 1'b0;
                end
                if (mgr_rlp_hs) begin
                    pending = 1'b1;
                    wait_left = rlpr_delay;
                    pend_page = mgr_pg;
                end
                if (pending) begin
                    if (wait_left == 0) begin
                        bus.rlpr_srdy = 1'b1;
                        bus.rlpr_data = link_mem[pend_page];
                        pending = 1'b0;
                    end else begin
                        wait_left--;
                    end
                end else if (spur_req && spur_count == 0 && mgr_emit_wait && !bus.rlpr_srdy) begin
                    bus.rlpr_srdy = 1'b1;
                    bus.rlpr_data = 9'h1AA;
                    spur_active = 1'b1;
                    spur_count++;
                end
            end
        end
    end

    // Compare process: protocol shape, hold-under-backpressure and transaction order every cycle.
    logic pw, rw, dw;
    logic [LPSZ-1:0] pw_page, rw_page, dw_page;
    logic pw_last;
    initial begin
        pw = 1'b0; rw = 1'b0; dw = 1'b0;
        pw_page = '0; rw_page = '0; dw_page = '0; pw_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pw = 1'b0; rw = 1'b0; dw = 1'b0;
                rlp_idx = exp_rlp.size();
                p_idx   = exp_p_page.size();
                drf_idx = exp_drf.size();
            end else begin
                checkOutput("one_ready", $countones({bus.c_drdy, bus.rlp_srdy, bus.rlpr_drdy,
                                                     bus.p_srdy, bus.drf_srdy}), 1);
                checkOutput("busy", busy, !bus.c_drdy);
                if (pw) begin
                    checkOutput("p_hold", bus.p_srdy, 1);
                    checkOutput("p_hold_page", bus.p_page, pw_page);
                    checkOutput("p_hold_last", bus.p_last, pw_last);
                end
                if (rw) begin
                    checkOutput("rlp_hold", bus.rlp_srdy, 1);
                    checkOutput("rlp_hold_page", bus.rlp_rd_page, rw_page);
                end
                if (dw) begin
                    checkOutput("drf_hold", bus.drf_srdy, 1);
                    checkOutput("drf_hold_page", bus.drf_page, dw_page);
                end
                if (err) err_seen++;
                if (bus.rlp_srdy && bus.rlp_drdy) begin
                    t_rlp = $time;
                    checkOutput("rlp_expected", rlp_idx < exp_rlp.size(), 1);
                    if (rlp_idx < exp_rlp.size()) begin
                        checkOutput("rlp_page", bus.rlp_rd_page, exp_rlp[rlp_idx]);
                        rlp_idx++;
                    end
                end
                if (bus.p_srdy && bus.p_drdy) begin
                    checkOutput("p_expected", p_idx < exp_p_page.size(), 1);
                    if (p_idx < exp_p_page.size()) begin
                        checkOutput("p_page", bus.p_page, exp_p_page[p_idx]);
                        checkOutput("p_last", bus.p_last, exp_p_last[p_idx]);
                        p_idx++;
                    end
                    obs_page.push_back(int'(bus.p_page));
                    obs_last.push_back(int'(bus.p_last));
                    p_fires++;
                end
                if (bus.drf_srdy && bus.drf_drdy) begin
                    checkOutput("drf_after_p", p_fires > drf_fires, 1);
                    checkOutput("drf_expected", drf_idx < exp_drf.size(), 1);
                    if (drf_idx < exp_drf.size()) begin
                        checkOutput("drf_page", bus.drf_page, exp_drf[drf_idx]);
                        drf_idx++;
                    end
                    drf_fires++;
                end
                pw = bus.p_srdy && !bus.p_drdy;     pw_page = bus.p_page;   pw_last = bus.p_last;
                rw = bus.rlp_srdy && !bus.rlp_drdy; rw_page = bus.rlp_rd_page;
                dw = bus.drf_srdy && !bus.drf_drdy; dw_page = bus.drf_page;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    time t0, t1;
    int base, err_snap, pf_snap, n;
    initial begin
        for (int i = 0; i < 256; i++) link_mem[i] = '0;
        reset = 1'b1;
        bus.c_srdy = 1'b0;
        bus.c_head_page = '0;
        bus.rlp_drdy = 1'b1;
        bus.p_drdy = 1'b1;
        bus.drf_drdy = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_c_drdy", bus.c_drdy, 1);
        checkOutput("rst_rlp_srdy", bus.rlp_srdy, 0);
        checkOutput("rst_rlpr_drdy", bus.rlpr_drdy, 0);
        checkOutput("rst_p_srdy", bus.p_srdy, 0);
        checkOutput("rst_drf_srdy", bus.drf_srdy, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pkt_pages", pkt_pages, 0);
        checkOutput("rst_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: three-page chain 5 -> 9 -> 3, everything ready.
        link_mem[5] = 9'h009; link_mem[9] = 9'h003; link_mem[3] = 9'h100;
        base = obs_page.size();
        buildChain(5);
        applyStimulus(5, t0);
        waitIdle("t1_done", t1);
        checkOutput("t1_cycles", int'((t1 - t0) / 10), 13);
        checkOutput("t1_pkt_pages", pkt_pages, 3);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_count", obs_page.size() - base, 3);
        if (obs_page.size() - base == 3) begin
            checkOutput("t1_page0", obs_page[base], 5);
            checkOutput("t1_page1", obs_page[base + 1], 9);
            checkOutput("t1_page2", obs_page[base + 2], 3);
            checkOutput("t1_last1", obs_last[base + 1], 0);
            checkOutput("t1_last2", obs_last[base + 2], 1);
        end

        // 2: single page 0 whose link word carries a don't-care next page 255.
        link_mem[0] = 9'h1FF;
        buildChain(0);
        applyStimulus(0, t0);
        waitIdle("t2_done", t1);
        checkOutput("t2_rlp_to_idle", int'((t1 - t_rlp) / 10), 4);
        checkOutput("t2_pkt_pages", pkt_pages, 1);
        checkOutput("t2_last", obs_last[obs_last.size() - 1], 1);

        // 3: downstream and dereference backpressure.
        link_mem[20] = 9'h015; link_mem[21] = 9'h100;
        @(posedge clk); #1;
        bus.p_drdy = 1'b0;
        bus.drf_drdy = 1'b0;
        buildChain(20);
        applyStimulus(20, t0);
        waitFor(0, "t3_p_seen");
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        bus.p_drdy = 1'b1;
        waitFor(1, "t3_drf_seen");
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        bus.drf_drdy = 1'b1;
        waitIdle("t3_done", t1);
        checkOutput("t3_pkt_pages", pkt_pages, 2);

        // 4: slow manager plus a stray link reply while a page waits downstream.
        link_mem[40] = 9'h029; link_mem[41] = 9'h02A; link_mem[42] = 9'h100;
        @(posedge clk); #1;
        bus.rlp_drdy = 1'b0;
        bus.p_drdy = 1'b0;
        rlpr_delay = 7;
        spur_req = 1'b1;
        buildChain(40);
        applyStimulus(40, t0);
        repeat (9) @(negedge clk);
        @(posedge clk); #1;
        bus.rlp_drdy = 1'b1;
        waitFor(0, "t4_p_seen");
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        bus.p_drdy = 1'b1;
        waitIdle("t4_done", t1);
        checkOutput("t4_spurious_sent", spur_count, 1);
        checkOutput("t4_pkt_pages", pkt_pages, 3);
        spur_req = 1'b0;
        rlpr_delay = 0;

        // 5: reset while page 11 (second of four) is being offered.
        link_mem[10] = 9'h00B; link_mem[11] = 9'h00C; link_mem[12] = 9'h00D; link_mem[13] = 9'h100;
        @(posedge clk); #1;
        bus.p_drdy = 1'b0;
        buildChain(10);
        applyStimulus(10, t0);
        n = 0;
        do begin
            waitFor(0, "t5_p_seen");
            n++;
            if (bus.p_page != 8'd11) begin
                @(posedge clk); #1; bus.p_drdy = 1'b1;
                @(posedge clk); #1; bus.p_drdy = 1'b0;
            end
        end while (bus.p_page != 8'd11 && n < 4);
        checkOutput("t5_at_page11", bus.p_page, 11);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_c_drdy", bus.c_drdy, 1);
        checkOutput("t5_rlp_srdy", bus.rlp_srdy, 0);
        checkOutput("t5_p_srdy", bus.p_srdy, 0);
        checkOutput("t5_drf_srdy", bus.drf_srdy, 0);
        checkOutput("t5_pkt_pages", pkt_pages, 0);
        @(posedge clk); #1;
        bus.p_drdy = 1'b1;
        link_mem[7] = 9'h008; link_mem[8] = 9'h100;
        buildChain(7);
        applyStimulus(7, t0);
        waitIdle("t5_done", t1);
        checkOutput("t5_new_pkt_pages", pkt_pages, 2);
        checkOutput("t5_new_last_page", obs_page[obs_page.size() - 1], 8);

        // 6: page 2 links to itself.
        link_mem[2] = 9'h002;
        err_snap = err_seen;
        base = obs_page.size();
`ifdef LLREADER_LOOP_GUARD_EN
        buildChain(2);
        applyStimulus(2, t0);
        waitIdle("t6_done", t1);
        checkOutput("t6_emitted", obs_page.size() - base, 5);
        checkOutput("t6_final_last", obs_last[obs_last.size() - 1], 1);
        checkOutput("t6_err_pulses", err_seen - err_snap, 1);
        checkOutput("t6_pkt_pages", pkt_pages, 4);
`else
        for (int i = 0; i < 7; i++) begin
            exp_rlp.push_back(2);
            exp_p_page.push_back(2);
            exp_p_last.push_back(i == 6 ? 1 : 0);
            exp_drf.push_back(2);
        end
        pf_snap = p_fires;
        applyStimulus(2, t0);
        n = 0;
        while (p_fires - pf_snap < 6 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_six_pages", p_fires - pf_snap >= 6, 1);
        link_mem[2] = 9'h102;
        waitIdle("t6_done", t1);
        checkOutput("t6_emitted", obs_page.size() - base, 7);
        checkOutput("t6_err_quiet", err_seen - err_snap, 0);
        checkOutput("t6_pkt_pages_sat", pkt_pages, 4);
`endif

        repeat (3) @(negedge clk);
        checkOutput("end_rlp_all", rlp_idx, exp_rlp.size());
        checkOutput("end_drf_all", drf_idx, exp_drf.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
